i2c_target_frontend: RTL and testbench
======================================

Name: i2c_target_frontend

Overview:
- I2C target (slave) protocol engine. It turns serial SCL/SDA traffic into register-level write strobes and read fetches for the PID gain register bank.
- Sits directly upstream of the gain registers. It drives their address and write data, and consumes their 6-bit read value.
- System clk oversamples the bus; clk must be at least 16x the SCL rate.

Parameters:
- DEV_ADDR, 7'h2A, 7-bit I2C target address this block responds to.
- FILT_LEN, 3, glitch-filter depth in clk cycles on synchronized SCL/SDA; a level must be stable this many cycles to be accepted.
- MAX_PTR, 8'h02, highest valid register pointer; used for pointer wrap.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- ena  in  1  block enable; when low, bus is ignored and FSM held in IDLE.
- scl_in  in  1  raw SCL pad input (asynchronous).
- sda_in  in  1  raw SDA pad input (asynchronous).
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- reg_addr  out  8  register pointer presented to the register bank.
- wr_data  out  6  write data (low 6 bits of received data byte).
- wr_en  out  1  one-clk write strobe; reg_addr/wr_data valid while high.
- rd_data  in  6  read value from the register bank; valid 2 clk after reg_addr changes.
- busy  out  1  high from accepted START with address match until STOP.

Behaviour:
- Reset (rst_n=0 at posedge clk) values:
  - sda_oe=0, wr_en=0, wr_data=0, reg_addr=0, busy=0.
  - FSM=IDLE, bit counter=0.
  - Filtered SCL/SDA preset to 1.
- Input conditioning: 2-FF synchronizer per line, then FILT_LEN-deep filter. Edges are detected on filtered signals only.
- START: filtered SDA 1->0 while SCL=1. Repeated START is accepted in any state. STOP: SDA 0->1 while SCL=1. STOP forces IDLE from any state and releases sda_oe the same cycle.
- Bits are sampled on SCL rising edge, MSB first. sda_oe changes only on SCL falling edge, one clk after edge detection.
- States:
  - IDLE: wait for START, then go to ADDR.
  - ADDR: shift 8 bits.
    - {addr,rw} with addr==DEV_ADDR: ACK, busy=1. rw=0 -> PTR. rw=1 -> RDATA.
    - Mismatch: no ACK; -> IDLE, which waits for the next START.
  - PTR: 8 bits into pointer; ACK; reg_addr <= pointer; -> WDATA.
  - WDATA: 8 bits. On the 8th SCL rise:
    - wr_data <= byte[5:0]; byte[7:6] discarded.
    - wr_en pulses exactly 1 clk.
    - ACK, then pointer advance (see Optional Feature); -> WDATA.
  - RDATA:
    - Load: on SCL fall after the ACK or address phase, present reg_addr; wait 2 clk; shift register <= {2'b00, rd_data}.
    - Shift: drive 8 bits, sda_oe = ~bit.
    - -> RDATA_ACK.
  - RDATA_ACK: release SDA and sample the master's bit. ACK(0): pointer advance, -> RDATA. NACK(1): -> IDLE (busy stays 1 until STOP).
- The only writes occur via wr_en. reg_addr is stable at least 2 clk before any read capture.
- Simultaneous events:
  - START/STOP take priority over data-bit sampling in the same clk.
  - Bus activity while ena=0 is ignored.
  - ena falling mid-transfer equals an implicit STOP.
- Reset mid-transaction: all outputs return to reset values next posedge. Any partial byte is discarded; no wr_en.

Optional Feature:
- Macro PTR_AUTO_INC_EN.
- Defined: after each data byte (write ACK or read ACK), pointer increments; pointer > MAX_PTR wraps to 0.
- Undefined: pointer never changes after PTR phase; repeated data bytes hit the same register.

Test Plan:
- Write START, 0x54, 0x01, 0x15, STOP:
  - Three ACKs.
  - One wr_en pulse with reg_addr=0x01, wr_data=0x15.
  - busy falls at STOP.
- Address mismatch, START, 0x56: sda_oe stays 0 for all 9 SCL; no wr_en; busy=0.
- Write pointer then read:
  - Sequence: START, 0x54, 0x02, Sr, 0x55, read 1 byte, NACK, STOP.
  - rd_data=0x2B at pointer 2 -> SDA shows 0x2B.
  - FSM returns IDLE after NACK.
- Burst write 0x54, 0x02, 0x11, 0x22 with PTR_AUTO_INC_EN:
  - wr_en at reg_addr 0x02 then 0x00 (wrap).
  - Without the macro: both writes at 0x02.
- Glitch: 1-clk low pulse on SDA while SCL high in IDLE -> no START detected, busy=0.
- Reset during WDATA after 4 bits -> outputs at reset values next cycle; no wr_en; a following full write succeeds.

Source files
------------

// File: rtl/i2c_target_frontend.sv
// ---------------------------------------------------------------------------
// i2c_target_frontend
//   I2C target protocol engine for the PID gain register bank. Oversamples
//   SCL/SDA on clk (clk >= 16x SCL), decodes START/STOP, the address byte,
//   a register pointer byte and data bytes, and turns them into register
//   write strobes and read fetches.
//
//   Optional build macro: PTR_AUTO_INC_EN
//     defined   -> pointer advances after every data byte, wrapping to 0
//                  once it would exceed MAX_PTR
//     undefined -> pointer only changes in the pointer phase
//
// Ports
//   clk       system clock
//   rst_n     synchronous active-low reset
//   ena       block enable; low holds the engine idle (acts as a STOP)
//   scl_in    raw SCL pad input (asynchronous)
//   sda_in    raw SDA pad input (asynchronous)
//   sda_oe    1 = pull SDA low, 0 = release
//   reg_addr  register pointer presented to the bank
//   wr_data   write data (low 6 bits of the received byte)
//   wr_en     one-clk write strobe
//   rd_data   read value from the bank (valid 2 clk after reg_addr changes)
//   busy      high from an address-matched START until STOP
// ---------------------------------------------------------------------------
module i2c_target_frontend #(
    parameter logic [6:0] DEV_ADDR = 7'h2A,
    parameter int         FILT_LEN = 3,
    parameter logic [7:0] MAX_PTR  = 8'h02
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [5:0] wr_data,
    output logic       wr_en,
    input  logic [5:0] rd_data,
    output logic       busy
);

`ifdef PTR_AUTO_INC_EN
    localparam bit AUTO_INC = 1'b1;
`else
    localparam bit AUTO_INC = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_PTR       = 3'd2,
        ST_WDATA     = 3'd3,
        ST_RDATA     = 3'd4,
        ST_RDATA_ACK = 3'd5
    } state_t;

    // Pointer advance after a data byte; a no-op unless auto-increment is built in.
    function automatic logic [7:0] ptr_adv(input logic [7:0] p);
        if (!AUTO_INC) begin
            return p;
        end else if (p >= MAX_PTR) begin
            return 8'h00;
        end else begin
            return p + 8'h01;
        end
    endfunction

    logic [1:0]          scl_sync_r, sda_sync_r;
    logic [FILT_LEN-1:0] scl_hist_r, sda_hist_r;
    logic                scl_f_r, sda_f_r, scl_p_r, sda_p_r;
    logic                scl_rise_s, scl_fall_s, start_s, stop_s;
    logic [7:0]          byte_s;

    state_t     state_r, state_nxt;
    logic [3:0] bit_cnt_r, bit_cnt_nxt;
    logic [7:0] shift_r, shift_nxt;
    logic [7:0] ptr_r, ptr_nxt;
    logic [5:0] wr_data_r, wr_data_nxt;
    logic       wr_en_r, wr_en_nxt;
    logic       sda_oe_r, sda_oe_nxt;
    logic       busy_r, busy_nxt;
    logic       ack_r, ack_nxt;
    logic       rw_r, rw_nxt;
    logic       ld_act_r, ld_act_nxt;
    logic [1:0] ld_cnt_r, ld_cnt_nxt;

    // Synchronize both lines, then accept a level only once it has been stable FILT_LEN clks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync_r <= 2'b11;
            sda_sync_r <= 2'b11;
            scl_hist_r <= {FILT_LEN{1'b1}};
            sda_hist_r <= {FILT_LEN{1'b1}};
            scl_f_r    <= 1'b1;
            sda_f_r    <= 1'b1;
            scl_p_r    <= 1'b1;
            sda_p_r    <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[0], scl_in};
            sda_sync_r <= {sda_sync_r[0], sda_in};
            scl_hist_r <= {scl_hist_r[FILT_LEN-2:0], scl_sync_r[1]};
            sda_hist_r <= {sda_hist_r[FILT_LEN-2:0], sda_sync_r[1]};
            if (&scl_hist_r) begin
                scl_f_r <= 1'b1;
            end else if (~|scl_hist_r) begin
                scl_f_r <= 1'b0;
            end
            if (&sda_hist_r) begin
                sda_f_r <= 1'b1;
            end else if (~|sda_hist_r) begin
                sda_f_r <= 1'b0;
            end
            scl_p_r <= scl_f_r;
            sda_p_r <= sda_f_r;
        end
    end

    assign scl_rise_s = scl_f_r & ~scl_p_r;
    assign scl_fall_s = ~scl_f_r & scl_p_r;
    assign start_s    = scl_f_r & scl_p_r & sda_p_r & ~sda_f_r;
    assign stop_s     = scl_f_r & scl_p_r & ~sda_p_r & sda_f_r;
    assign byte_s     = {shift_r[6:0], sda_f_r};

    // Protocol state register and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 4'd0;
            shift_r   <= 8'h00;
            ptr_r     <= 8'h00;
            wr_data_r <= 6'h00;
            wr_en_r   <= 1'b0;
            sda_oe_r  <= 1'b0;
            busy_r    <= 1'b0;
            ack_r     <= 1'b0;
            rw_r      <= 1'b0;
            ld_act_r  <= 1'b0;
            ld_cnt_r  <= 2'd0;
        end else begin
            state_r   <= state_nxt;
            bit_cnt_r <= bit_cnt_nxt;
            shift_r   <= shift_nxt;
            ptr_r     <= ptr_nxt;
            wr_data_r <= wr_data_nxt;
            wr_en_r   <= wr_en_nxt;
            sda_oe_r  <= sda_oe_nxt;
            busy_r    <= busy_nxt;
            ack_r     <= ack_nxt;
            rw_r      <= rw_nxt;
            ld_act_r  <= ld_act_nxt;
            ld_cnt_r  <= ld_cnt_nxt;
        end
    end

    // Next-state and next-output decode; bus conditions outrank bit events.
    always_comb begin
        state_nxt   = state_r;
        bit_cnt_nxt = bit_cnt_r;
        shift_nxt   = shift_r;
        ptr_nxt     = ptr_r;
        wr_data_nxt = wr_data_r;
        wr_en_nxt   = 1'b0;
        sda_oe_nxt  = sda_oe_r;
        busy_nxt    = busy_r;
        ack_nxt     = ack_r;
        rw_nxt      = rw_r;
        ld_act_nxt  = ld_act_r;
        ld_cnt_nxt  = ld_cnt_r;
        if (!ena || stop_s) begin
            state_nxt   = ST_IDLE;
            bit_cnt_nxt = 4'd0;
            sda_oe_nxt  = 1'b0;
            busy_nxt    = 1'b0;
            ld_act_nxt  = 1'b0;
        end else if (start_s) begin
            state_nxt   = ST_ADDR;
            bit_cnt_nxt = 4'd0;
            sda_oe_nxt  = 1'b0;
            ld_act_nxt  = 1'b0;
            ack_nxt     = 1'b0;
        end else begin
            case (state_r)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    // bit_cnt 0..7: data bits; 8: byte done, ACK pending; 9: ACK clock seen
                    if (scl_rise_s) begin
                        if (bit_cnt_r < 4'd8) begin
                            shift_nxt   = byte_s;
                            bit_cnt_nxt = bit_cnt_r + 4'd1;
                            if (bit_cnt_r == 4'd7) begin
                                if (state_r == ST_ADDR) begin
                                    if (byte_s[7:1] == DEV_ADDR) begin
                                        ack_nxt  = 1'b1;
                                        busy_nxt = 1'b1;
                                        rw_nxt   = byte_s[0];
                                    end else begin
                                        ack_nxt     = 1'b0;
                                        state_nxt   = ST_IDLE;
                                        bit_cnt_nxt = 4'd0;
                                    end
                                end else if (state_r == ST_PTR) begin
                                    ptr_nxt = byte_s;
                                    ack_nxt = 1'b1;
                                end else begin
                                    wr_data_nxt = byte_s[5:0];
                                    wr_en_nxt   = 1'b1;
                                    ack_nxt     = 1'b1;
                                end
                            end else begin
                                ack_nxt = 1'b0;
                            end
                        end else begin
                            bit_cnt_nxt = 4'd9;
                            if (state_r == ST_WDATA) begin
                                ptr_nxt = ptr_adv(ptr_r);
                            end else begin
                                ptr_nxt = ptr_r;
                            end
                        end
                    end else if (scl_fall_s) begin
                        if (bit_cnt_r == 4'd8) begin
                            sda_oe_nxt = ack_r;
                        end else if (bit_cnt_r == 4'd9) begin
                            sda_oe_nxt  = 1'b0;
                            bit_cnt_nxt = 4'd0;
                            if (state_r == ST_ADDR && rw_r) begin
                                state_nxt  = ST_RDATA;
                                ld_act_nxt = 1'b1;
                                ld_cnt_nxt = 2'd0;
                            end else if (state_r == ST_ADDR) begin
                                state_nxt = ST_PTR;
                            end else begin
                                state_nxt = ST_WDATA;
                            end
                        end else begin
                            sda_oe_nxt = 1'b0;
                        end
                    end else begin
                        state_nxt = state_r;
                    end
                end
                ST_RDATA: begin
                    // Load waits two clk after entry so rd_data reflects reg_addr; bit 7 goes out on capture.
                    if (ld_act_r) begin
                        if (ld_cnt_r == 2'd2) begin
                            shift_nxt   = {2'b00, rd_data};
                            sda_oe_nxt  = 1'b1;
                            ld_act_nxt  = 1'b0;
                            bit_cnt_nxt = 4'd0;
                        end else begin
                            ld_cnt_nxt = ld_cnt_r + 2'd1;
                        end
                    end else if (scl_rise_s) begin
                        bit_cnt_nxt = bit_cnt_r + 4'd1;
                    end else if (scl_fall_s) begin
                        if (bit_cnt_r == 4'd8) begin
                            sda_oe_nxt  = 1'b0;
                            bit_cnt_nxt = 4'd0;
                            state_nxt   = ST_RDATA_ACK;
                        end else begin
                            shift_nxt  = {shift_r[6:0], 1'b0};
                            sda_oe_nxt = ~shift_r[6];
                        end
                    end else begin
                        state_nxt = state_r;
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_rise_s) begin
                        if (!sda_f_r) begin
                            ptr_nxt     = ptr_adv(ptr_r);
                            bit_cnt_nxt = 4'd1;
                        end else begin
                            state_nxt   = ST_IDLE;
                            bit_cnt_nxt = 4'd0;
                        end
                    end else if (scl_fall_s && bit_cnt_r == 4'd1) begin
                        state_nxt   = ST_RDATA;
                        bit_cnt_nxt = 4'd0;
                        ld_act_nxt  = 1'b1;
                        ld_cnt_nxt  = 2'd0;
                    end else begin
                        state_nxt = state_r;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign sda_oe   = sda_oe_r;
    assign reg_addr = ptr_r;
    assign wr_data  = wr_data_r;
    assign wr_en    = wr_en_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_i2c_target_frontend.sv
// ---------------------------------------------------------------------------
// tb_i2c_target_frontend
//   Bit-banged I2C master driving i2c_target_frontend, a small register bank
//   answering rd_data, a table of directed write transactions, hand-written
//   corner sequences and randomized write/read transactions checked against a
//   transaction-level model of the register bank and pointer.
// ---------------------------------------------------------------------------
module tb_i2c_target_frontend;

    localparam int         Q        = 8;
    localparam logic [7:0] MAX_PTR  = 8'h02;
`ifdef PTR_AUTO_INC_EN
    localparam bit         AUTO     = 1'b1;
    localparam logic [7:0] BURST2   = 8'h00;
`else
    localparam bit         AUTO     = 1'b0;
    localparam logic [7:0] BURST2   = 8'h02;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [5:0] wr_data;
    logic       wr_en;
    logic [5:0] rd_data = 6'h00;
    logic       busy;
    wire        sda_line;

    assign sda_line = sda_m & ~sda_oe;

    i2c_target_frontend dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .scl_in   (scl_m),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .reg_addr (reg_addr),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .rd_data  (rd_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Register bank seen by the DUT, plus a log of every write strobe.
    logic [5:0]  bank   [0:255];
    logic        bvalid [0:255];
    logic [5:0]  rd_p1 = 6'h00;
    logic [13:0] wr_log [0:255];
    int          wr_cnt = 0;
    int          oe_cnt = 0;

    function automatic logic [5:0] init_val(input logic [7:0] a);
        return 6'(a * 8'd5 + 8'd3);
    endfunction

    function automatic logic [5:0] bank_rd(input logic [7:0] a);
        return (bvalid[a] === 1'b1) ? bank[a] : init_val(a);
    endfunction

    always @(posedge clk) begin
        rd_p1   <= bank_rd(reg_addr);
        rd_data <= rd_p1;
        if (wr_en) begin
            bank[reg_addr]       <= wr_data;
            bvalid[reg_addr]     <= 1'b1;
            wr_log[wr_cnt[7:0]]  <= {reg_addr, wr_data};
            wr_cnt               <= wr_cnt + 1;
        end
        if (sda_oe) oe_cnt <= oe_cnt + 1;
    end

    // Reference model: register contents and pointer rule at transaction level.
    logic [5:0]  mbank  [0:255];
    logic        mvalid [0:255];
    logic [13:0] exp_w  [0:2];
    logic [7:0]  got_b  [0:2];

    function automatic logic [7:0] m_next(input logic [7:0] p);
        int nx;
        nx = int'(p) + 1;
        if (!AUTO) return p;
        return (nx > int'(MAX_PTR)) ? 8'h00 : 8'(nx);
    endfunction

    function automatic logic [5:0] m_read(input logic [7:0] p);
        return (mvalid[p] === 1'b1) ? mbank[p] : init_val(p);
    endfunction

    task automatic model_write(input logic [7:0] p, input int n,
                               input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        logic [7:0] d [0:2];
        logic [7:0] mp;
        d[0] = d0; d[1] = d1; d[2] = d2;
        mp = p;
        for (int k = 0; k < n; k++) begin
            exp_w[k]  = {mp, d[k][5:0]};
            mbank[mp] = d[k][5:0];
            mvalid[mp] = 1'b1;
            mp = m_next(mp);
        end
    endtask

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_wr(input string tag, input int snap, input int n);
        check({tag, "_nwr"}, 32'(wr_cnt - snap), 32'(n));
        for (int k = 0; k < n && k < 3; k++) begin
            if (snap + k < wr_cnt)
                check($sformatf("%s_wr%0d", tag, k), 32'(wr_log[8'(snap + k)]), 32'(exp_w[k]));
        end
    endtask

    // ---------------- bus master ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic bus_start();
        if (scl_m) begin
            sda_m = 1'b0; wait_clk(Q); scl_m = 1'b0;
        end else begin
            wait_clk(Q); sda_m = 1'b1; wait_clk(Q); scl_m = 1'b1;
            wait_clk(Q); sda_m = 1'b0; wait_clk(Q); scl_m = 1'b0;
        end
    endtask

    task automatic bus_stop();
        wait_clk(Q); sda_m = 1'b0; wait_clk(Q); scl_m = 1'b1;
        wait_clk(Q); sda_m = 1'b1; wait_clk(2 * Q);
    endtask

    task automatic bus_bit(input logic b, output logic s);
        wait_clk(Q); sda_m = b; wait_clk(Q); scl_m = 1'b1;
        wait_clk(Q); #1 s = sda_line; wait_clk(Q); scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] b);
        logic s;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bus_bit(1'b1, s);
            b = {b[6:0], s};
        end
        bus_bit(nack, s);
    endtask

    task automatic do_write(input logic [7:0] ab, input logic [7:0] p, input int n,
                            input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                            output int acks, output logic bmid);
        logic       a;
        logic [7:0] d [0:2];
        d[0] = d0; d[1] = d1; d[2] = d2;
        acks = 0;
        bus_start();
        send_byte(ab, a);
        #1 bmid = busy;
        if (a) begin
            acks++;
            send_byte(p, a);
            if (a) acks++;
            for (int k = 0; k < n; k++) begin
                send_byte(d[k], a);
                if (a) acks++;
            end
        end
        bus_stop();
    endtask

    task automatic do_read(input logic [7:0] p, input int n, output int acks, output logic bpre);
        logic       a;
        logic [7:0] b;
        acks = 0;
        bus_start();
        send_byte(8'h54, a); if (a) acks++;
        send_byte(p, a);     if (a) acks++;
        bus_start();
        send_byte(8'h55, a); if (a) acks++;
        for (int k = 0; k < n; k++) begin
            recv_byte(k == n - 1, b);
            got_b[k] = b;
        end
        wait_clk(4);
        #1 bpre = busy;
        bus_stop();
    endtask

    typedef struct {
        logic [7:0] addr_b;
        logic [7:0] ptr;
        int         n;
        logic [7:0] d0;
        logic [7:0] d1;
        int         exp_acks;
        int         exp_nwr;
        logic [7:0] ea0;
        logic [5:0] ed0;
        logic [7:0] ea1;
        logic [5:0] ed1;
        logic       exp_oe;
    } vec_t;

    initial begin
        vec_t       tbl [0:3];
        int         acks, snap, oe0, n;
        logic       bmid, bpre, a, s;
        logic [7:0] p, mp, d0, d1, d2;
        logic [7:0] exp_b [0:2];

        for (int i = 0; i < 256; i++) begin
            mvalid[i] = 1'b0;
            mbank[i]  = 6'h00;
        end

        tbl[0] = '{8'h54, 8'h01, 1, 8'h15, 8'h00, 3, 1, 8'h01, 6'h15, 8'h00, 6'h00, 1'b1};
        tbl[1] = '{8'h56, 8'h00, 0, 8'h00, 8'h00, 0, 0, 8'h00, 6'h00, 8'h00, 6'h00, 1'b0};
        tbl[2] = '{8'h54, 8'h02, 2, 8'h11, 8'h22, 4, 2, 8'h02, 6'h11, BURST2, 6'h22, 1'b1};
        tbl[3] = '{8'h54, 8'h00, 1, 8'hFF, 8'h00, 3, 1, 8'h00, 6'h3F, 8'h00, 6'h00, 1'b1};

        rst_n = 1'b0;
        wait_clk(4);
        #1 check("reset_outs", 32'({sda_oe, wr_en, wr_data, reg_addr, busy}), 32'd0);
        rst_n = 1'b1;
        ena   = 1'b1;
        wait_clk(10);

        // Directed table
        for (int i = 0; i < 4; i++) begin
            snap = wr_cnt;
            oe0  = oe_cnt;
            do_write(tbl[i].addr_b, tbl[i].ptr, tbl[i].n, tbl[i].d0, tbl[i].d1, 8'h00, acks, bmid);
            wait_clk(4);
            #1;
            check($sformatf("tbl%0d_acks", i), 32'(acks), 32'(tbl[i].exp_acks));
            check($sformatf("tbl%0d_busy_mid", i), 32'(bmid), 32'(tbl[i].exp_acks > 0));
            check($sformatf("tbl%0d_busy_end", i), 32'(busy), 32'd0);
            check($sformatf("tbl%0d_oe_seen", i), 32'(oe_cnt != oe0), 32'(tbl[i].exp_oe));
            exp_w[0] = {tbl[i].ea0, tbl[i].ed0};
            exp_w[1] = {tbl[i].ea1, tbl[i].ed1};
            check_wr($sformatf("tbl%0d", i), snap, tbl[i].exp_nwr);
            if (tbl[i].exp_acks > 0) model_write(tbl[i].ptr, tbl[i].n, tbl[i].d0, tbl[i].d1, 8'h00);
        end

        // Glitch on SDA while SCL high must not look like a START
        wait_clk(10);
        @(posedge clk); #1 sda_m = 1'b0;
        @(posedge clk); #1 sda_m = 1'b1;
        wait_clk(20);
        #1 check("glitch_busy", 32'(busy), 32'd0);
        scl_m = 1'b0;
        send_byte(8'h54, a);
        check("glitch_no_ack", 32'(a), 32'd0);
        bus_stop();

        // Disabled block ignores the bus
        ena  = 1'b0;
        snap = wr_cnt;
        do_write(8'h54, 8'h00, 1, 8'h07, 8'h00, 8'h00, acks, bmid);
        check("ena_off_acks", 32'(acks), 32'd0);
        check("ena_off_nwr", 32'(wr_cnt - snap), 32'd0);
        ena = 1'b1;
        wait_clk(10);

        // Pointer write then repeated-START read of 0x2B at pointer 2
        model_write(8'h02, 1, 8'h2B, 8'h00, 8'h00);
        do_write(8'h54, 8'h02, 1, 8'h2B, 8'h00, 8'h00, acks, bmid);
        do_read(8'h02, 1, acks, bpre);
        check("rd_acks", 32'(acks), 32'd3);
        check("rd_byte", 32'(got_b[0]), 32'h2B);
        check("rd_busy_after_nack", 32'(bpre), 32'd1);
        wait_clk(4);
        #1 check("rd_busy_after_stop", 32'(busy), 32'd0);

        // Reset in the middle of a data byte
        snap = wr_cnt;
        bus_start();
        send_byte(8'h54, a);
        send_byte(8'h01, a);
        for (int i = 0; i < 4; i++) bus_bit(i[0], s);
        sda_m = 1'b1;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_outs", 32'({sda_oe, wr_en, wr_data, reg_addr, busy}), 32'd0);
        rst_n = 1'b1;
        wait_clk(20);
        bus_stop();
        check("midrst_nwr", 32'(wr_cnt - snap), 32'd0);
        snap = wr_cnt;
        model_write(8'h00, 1, 8'h2A, 8'h00, 8'h00);
        do_write(8'h54, 8'h00, 1, 8'h2A, 8'h00, 8'h00, acks, bmid);
        wait_clk(4);
        check("postrst_acks", 32'(acks), 32'd3);
        check_wr("postrst", snap, 1);

        // Randomized writes and reads against the model
        for (int r = 0; r < 8; r++) begin
            p  = 8'($urandom_range(0, 3));
            n  = $urandom_range(1, 3);
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            d2 = 8'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                snap = wr_cnt;
                model_write(p, n, d0, d1, d2);
                do_write(8'h54, p, n, d0, d1, d2, acks, bmid);
                wait_clk(4);
                check($sformatf("rnd%0d_wacks", r), 32'(acks), 32'(n + 2));
                check_wr($sformatf("rnd%0d", r), snap, n);
            end else begin
                mp = p;
                for (int k = 0; k < n; k++) begin
                    exp_b[k] = {2'b00, m_read(mp)};
                    if (k < n - 1) mp = m_next(mp);
                end
                do_read(p, n, acks, bpre);
                check($sformatf("rnd%0d_racks", r), 32'(acks), 32'd3);
                for (int k = 0; k < n; k++)
                    check($sformatf("rnd%0d_rd%0d", r, k), 32'(got_b[k]), 32'(exp_b[k]));
            end
            wait_clk(10);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
